// File: rtl/atomrvcore_fetch_unit.sv
// Instruction fetch stage: PC, imem req/gnt/rvalid handshake, instruction register
// and decode fields, and next-PC selection from control-unit redirects.
module atomrvcore_fetch_unit #(
    parameter int                     DATAWIDTH = 32,
    parameter int                     ADDRWIDTH = 32,
    parameter logic [ADDRWIDTH-1:0]   RESET_PC  = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    output logic                 instr_req_o,
    output logic [ADDRWIDTH-1:0] instr_addr_o,
    input  logic                 instr_gnt_i,
    input  logic                 instr_rvalid_i,
    input  logic [DATAWIDTH-1:0] instr_rdata_i,
    output logic                 instr_valid_o,
    input  logic                 instr_ready_i,
    output logic [DATAWIDTH-1:0] instr_o,
    output logic [ADDRWIDTH-1:0] pc_o,
    output logic [6:0]           opcode_o,
    output logic [2:0]           func3_o,
    output logic [6:0]           func7_o,
    output logic [4:0]           rd_o,
    output logic [4:0]           rs1_o,
    output logic [4:0]           rs2_o,
    input  logic                 be_i,
    input  logic                 jalre_i,
    input  logic                 uje_i,
    input  logic [ADDRWIDTH-1:0] sb_imm_i,
    input  logic [ADDRWIDTH-1:0] uj_imm_i,
    input  logic [ADDRWIDTH-1:0] jalr_addr_i,
    output logic                 misalign_o
);

    localparam logic [DATAWIDTH-1:0] NOP = DATAWIDTH'(32'h0000_0013);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, ERR} state_e;

    state_e                 state_q, state_d;
    logic [ADDRWIDTH-1:0]   pc_q, pc_d;
    logic [ADDRWIDTH-1:0]   ir_pc_q, ir_pc_d;
    logic [DATAWIDTH-1:0]   ir_q, ir_d;
    logic                   req_q, req_d;
    logic                   valid_q, valid_d;
    logic                   misalign_q, misalign_d;
    logic [ADDRWIDTH-1:0]   next_pc;

    // JALR target always has bit 0 cleared; bit 1 can still leave it misaligned.
    always_comb begin
        next_pc = pc_q + ADDRWIDTH'(4);
        if (jalre_i)
            next_pc = jalr_addr_i & ~ADDRWIDTH'(1);
        else if (uje_i)
            next_pc = pc_q + uj_imm_i;
        else if (be_i)
            next_pc = pc_q + sb_imm_i;
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_pc_d    = ir_pc_q;
        ir_d       = ir_q;
        req_d      = req_q;
        valid_d    = valid_q;
        misalign_d = misalign_q;
        unique case (state_q)
            IDLE: begin
                state_d = REQ;
                req_d   = 1'b1;
            end
            REQ: begin
                if (instr_gnt_i) begin
                    state_d = WAIT;
                    req_d   = 1'b0;
                end
            end
            WAIT: begin
                if (instr_rvalid_i) begin
                    state_d = HOLD;
                    ir_d    = instr_rdata_i;
                    ir_pc_d = pc_q;
                    valid_d = 1'b1;
                end
            end
            HOLD: begin
                if (instr_ready_i) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    if (next_pc[1:0] != 2'b00) begin
                        state_d    = ERR;
                        misalign_d = 1'b1;
                    end else begin
                        state_d = REQ;
                        req_d   = 1'b1;
                    end
                end
            end
            ERR: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            ir_pc_q    <= RESET_PC;
            ir_q       <= NOP;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_pc_q    <= ir_pc_d;
            ir_q       <= ir_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    assign instr_req_o   = req_q;
    assign instr_addr_o  = pc_q;
    assign instr_valid_o = valid_q;
    assign instr_o       = ir_q;
    assign pc_o          = ir_pc_q;
    assign opcode_o      = ir_q[6:0];
    assign rd_o          = ir_q[11:7];
    assign func3_o       = ir_q[14:12];
    assign rs1_o         = ir_q[19:15];
    assign rs2_o         = ir_q[24:20];
    assign func7_o       = ir_q[31:25];
    assign misalign_o    = misalign_q;

endmodule
